// File: rtl/z80_ex_sp_sequencer_pkg.sv
// Shared definitions for the EX (SP),rr exchange sequencer: register-pair
// select encoding and the sequencer state enum.
package z80_ex_sp_sequencer_pkg;

    localparam logic [1:0] SEL_HL = 2'b00;
    localparam logic [1:0] SEL_IX = 2'b01;
    localparam logic [1:0] SEL_IY = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_HI,
        WR_LO,
        FIN
    } seq_state_e;

    // Reserved select code 11 writes back to HL.
    function automatic logic [1:0] norm_sel(input logic [1:0] s);
        case (s)
            SEL_IX:  return SEL_IX;
            SEL_IY:  return SEL_IY;
            default: return SEL_HL;
        endcase
    endfunction

endpackage

// File: rtl/z80_ex_sp_sequencer.sv
// EX (SP),HL/IX/IY sequencer: two reads then two writes on a req/ack bus,
// returns the swapped word and a retire record for the instruction checker.
module z80_ex_sp_sequencer
    import z80_ex_sp_sequencer_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic [15:0] sp_in,
    input  logic [15:0] reg_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        reg_we,
    output logic [1:0]  reg_sel,
    output logic [15:0] reg_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] fi_raddr,
    output logic [15:0] fi_raddr2,
    output logic [15:0] fi_waddr,
    output logic [15:0] fi_waddr2,
    output logic [7:0]  fi_rdata,
    output logic [7:0]  fi_rdata2,
    output logic [7:0]  fi_wdata,
    output logic [7:0]  fi_wdata2
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    seq_state_e       state_q, state_d;
    logic [15:0]      spl_q, spl_d, spl1_q, r_q, r_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       rd_q, rd_d, rd2_q, rd2_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             xfer, timeout;
    logic             busy_d, done_d, err_d, req_d, we_d;
    logic [15:0]      addr_d, reg_out_d;
    logic [7:0]       wdata_d;

    assign xfer    = mem_req && mem_ack;
    assign timeout = (ACK_TIMEOUT != 0) && ((32'(wcnt_q) + 32'd1) >= ACK_TIMEOUT);

    // Next state, latches and the next values of every registered output.
    always_comb begin
        state_d = state_q;
        spl_d   = spl_q;
        r_d     = r_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        rd2_d   = rd2_q;
        wcnt_d  = wcnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    spl_d   = sp_in;
                    r_d     = reg_in;
                    sel_d   = norm_sel(sel);
                    wcnt_d  = '0;
                    state_d = RD_LO;
                end
            end
            RD_LO, RD_HI, WR_HI, WR_LO: begin
                if (xfer) begin
                    wcnt_d = '0;
                    case (state_q)
                        RD_LO:   begin rd_d  = mem_rdata; state_d = RD_HI; end
                        RD_HI:   begin rd2_d = mem_rdata; state_d = WR_HI; end
                        WR_HI:   state_d = WR_LO;
                        default: state_d = FIN;
                    endcase
                end else if (timeout) begin
                    wcnt_d  = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = 16'h0000;
        wdata_d = 8'h00;
        case (state_d)
            RD_LO: begin req_d = 1'b1; addr_d = spl_d; end
            RD_HI: begin req_d = 1'b1; addr_d = spl_d + 16'd1; end
            WR_HI: begin req_d = 1'b1; we_d = 1'b1; addr_d = spl_d + 16'd1; wdata_d = r_d[15:8]; end
            WR_LO: begin req_d = 1'b1; we_d = 1'b1; addr_d = spl_d; wdata_d = r_d[7:0]; end
            default: ;
        endcase

        done_d    = (state_d == FIN);
        busy_d    = (state_d != IDLE) || err_d;
        reg_out_d = done_d ? {rd2_d, rd_d} : reg_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            spl_q     <= 16'h0000;
            spl1_q    <= 16'h0000;
            r_q       <= 16'h0000;
            sel_q     <= 2'b00;
            rd_q      <= 8'h00;
            rd2_q     <= 8'h00;
            wcnt_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            reg_we    <= 1'b0;
            reg_out   <= 16'h0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
        end else begin
            state_q   <= state_d;
            spl_q     <= spl_d;
            spl1_q    <= spl_d + 16'd1;
            r_q       <= r_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            rd2_q     <= rd2_d;
            wcnt_q    <= wcnt_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            reg_we    <= done_d;
            reg_out   <= reg_out_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    assign reg_sel   = sel_q;
    assign fi_raddr  = spl_q;
    assign fi_waddr  = spl_q;
    assign fi_raddr2 = spl1_q;
    assign fi_waddr2 = spl1_q;
    assign fi_rdata  = rd_q;
    assign fi_rdata2 = rd2_q;
    assign fi_wdata  = r_q[7:0];
    assign fi_wdata2 = r_q[15:8];

endmodule

// File: tb/tb_z80_ex_sp_sequencer.sv
// Scoreboard bench for z80_ex_sp_sequencer: bus memory responder with
// programmable wait states, expected bus ops and results queued at issue.
`timescale 1ns/1ps
module tb_z80_ex_sp_sequencer;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [15:0] sp_in = 16'h0000, reg_in = 16'h0000;
    logic        busy, done, err, reg_we;
    logic [1:0]  reg_sel;
    logic [15:0] reg_out;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] fi_raddr, fi_raddr2, fi_waddr, fi_waddr2;
    logic [7:0]  fi_rdata, fi_rdata2, fi_wdata, fi_wdata2;

    z80_ex_sp_sequencer #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .sp_in(sp_in), .reg_in(reg_in),
        .busy(busy), .done(done), .err(err), .reg_we(reg_we), .reg_sel(reg_sel), .reg_out(reg_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fi_raddr(fi_raddr), .fi_raddr2(fi_raddr2), .fi_waddr(fi_waddr), .fi_waddr2(fi_waddr2),
        .fi_rdata(fi_rdata), .fi_rdata2(fi_rdata2), .fi_wdata(fi_wdata), .fi_wdata2(fi_wdata2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_t;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [15:0] val;
        logic [1:0]  rsel;
        logic [15:0] a, a2;
        logic [7:0]  rd, rd2, wd, wd2;
    } res_t;

    logic [7:0] mem [65536];
    bus_t exp_bus[$];
    res_t exp_res[$];
    int   wait_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder and bus monitor: a handshake seen at one negedge is
    // committed (checked and applied to memory) at the next one.
    int   wcnt = 0, cur_w;
    bit   hs_pend = 0, prev_req = 0;
    bus_t prev_bus, be;
    always @(negedge clk) begin
        if (hs_pend) begin
            chk("bus_expected", exp_bus.size() != 0, 1);
            if (exp_bus.size() != 0) begin
                be = exp_bus.pop_front();
                chk("bus_we", prev_bus.we, be.we);
                chk("bus_addr", prev_bus.addr, be.addr);
                if (be.we) chk("bus_wdata", prev_bus.wdata, be.wdata);
            end
            if (prev_bus.we) mem[prev_bus.addr] = prev_bus.wdata;
            if (wait_q.size() != 0) void'(wait_q.pop_front());
            wcnt = 0;
        end else if (prev_req && mem_req) begin
            wcnt++;
            chk("hold_we", mem_we, prev_bus.we);
            chk("hold_addr", mem_addr, prev_bus.addr);
            chk("hold_wdata", mem_wdata, prev_bus.wdata);
        end
        if (!mem_req) wcnt = 0;
        if (mem_req) begin
            cur_w = (wait_q.size() != 0) ? wait_q[0] : 0;
            mem_ack = (wcnt >= cur_w);
            mem_rdata = mem_ack ? mem[mem_addr] : 8'($urandom);
        end else begin
            mem_ack = 1'($urandom);
            mem_rdata = 8'($urandom);
        end
        hs_pend  = mem_req && mem_ack;
        prev_req = mem_req;
        prev_bus = '{mem_we, mem_addr, mem_wdata};
    end

    // Completion monitor.
    res_t re;
    bit   prev_end = 0;
    always @(negedge clk) begin
        if (prev_end) chk("busy_after_end", busy, 0);
        if (done || err || reg_we) begin
            chk("done_err_excl", done && err, 0);
            chk("reg_we_eq_done", reg_we, done);
            chk("busy_at_end", busy, 1);
            chk("end_expected", exp_res.size() != 0, 1);
            if (exp_res.size() != 0) begin
                re = exp_res.pop_front();
                chk("end_kind_err", err, re.is_err);
                chk("end_cycle", cyc, re.cyc);
                if (done) begin
                    chk("reg_out", reg_out, re.val);
                    chk("reg_sel", reg_sel, re.rsel);
                    chk("fi_raddr", fi_raddr, re.a);
                    chk("fi_waddr", fi_waddr, re.a);
                    chk("fi_raddr2", fi_raddr2, re.a2);
                    chk("fi_waddr2", fi_waddr2, re.a2);
                    chk("fi_rdata", fi_rdata, re.rd);
                    chk("fi_rdata2", fi_rdata2, re.rd2);
                    chk("fi_wdata", fi_wdata, re.wd);
                    chk("fi_wdata2", fi_wdata2, re.wd2);
                end
            end
        end
        prev_end = done || err;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    // mode 0: normal, 1: extra start while busy, 2: ack withheld in WR_HI
    task automatic run_txn(input logic [15:0] sp, input logic [15:0] rv, input logic [1:0] s,
                           input int w0, input int w1, input int w2, input int w3, input int mode);
        res_t        r;
        logic [15:0] sp1;
        int          n = 0;
        wait_idle();
        sp1      = sp + 16'd1;
        sp_in    = sp;
        reg_in   = rv;
        sel      = s;
        start    = 1'b1;
        r.is_err = (mode == 2);
        r.val    = {mem[sp1], mem[sp]};
        r.rsel   = (s == 2'b11) ? 2'b00 : s;
        r.a      = sp;
        r.a2     = sp1;
        r.rd     = mem[sp];
        r.rd2    = mem[sp1];
        r.wd     = rv[7:0];
        r.wd2    = rv[15:8];
        exp_bus.push_back('{1'b0, sp, 8'h00});
        exp_bus.push_back('{1'b0, sp1, 8'h00});
        if (mode == 2) begin
            wait_q = {w0, w1, 100000, 0};
            r.cyc  = cyc + 3 + w0 + w1 + int'(TMO);
        end else begin
            wait_q = {w0, w1, w2, w3};
            r.cyc  = cyc + 5 + w0 + w1 + w2 + w3;
            exp_bus.push_back('{1'b1, sp1, rv[15:8]});
            exp_bus.push_back('{1'b1, sp, rv[7:0]});
        end
        exp_res.push_back(r);
        @(negedge clk);
        start  = 1'b0;
        sp_in  = 16'($urandom);
        reg_in = 16'($urandom);
        sel    = 2'($urandom);
        if (mode == 1) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (exp_res.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("txn_drain", exp_res.size(), 0);
        chk("bus_drain", exp_bus.size(), 0);
        exp_res.delete();
        exp_bus.delete();
        wait_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  old_b;
        logic [15:0] sp;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_reg_sel", reg_sel, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_fi_raddr2", fi_raddr2, 0);
        chk("rst_fi_wdata2", fi_wdata2, 0);
        @(negedge clk);
        reset = 1'b0;

        // Zero-wait IX exchange
        mem[16'h1234] = 8'h11;
        mem[16'h1235] = 8'h22;
        run_txn(16'h1234, 16'hABCD, 2'b01, 0, 0, 0, 0, 0);
        chk("ix_mem_lo", mem[16'h1234], 8'hCD);
        chk("ix_mem_hi", mem[16'h1235], 8'hAB);

        // SP wrap with IY
        run_txn(16'hFFFF, 16'h5A5A, 2'b10, 0, 0, 0, 0, 0);
        chk("wrap_mem_ffff", mem[16'hFFFF], 8'h5A);
        chk("wrap_mem_0000", mem[16'h0000], 8'h5A);

        // Three wait states on the high read
        run_txn(16'h4000, 16'h1357, 2'b00, 0, 3, 0, 0, 0);

        // start while busy is ignored
        run_txn(16'h2468, 16'h9BDF, 2'b11, 0, 0, 0, 0, 1);

        // Timeout in WR_HI
        sp = 16'h8000;
        old_b = mem[16'h8001];
        run_txn(sp, 16'hC3C3, 2'b01, 0, 0, 0, 0, 2);
        chk("tmo_mem_hi_unwritten", mem[16'h8001], old_b);
        chk("tmo_busy_low", busy, 0);

        // Async reset while waiting in RD_HI
        wait_idle();
        sp_in  = 16'h6000;
        reg_in = 16'h7777;
        sel    = 2'b10;
        start  = 1'b1;
        exp_bus.push_back('{1'b0, 16'h6000, 8'h00});
        wait_q = {0, 100000, 0, 0};
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_reg_we", reg_we, 0);
        chk("arst_fi_raddr", fi_raddr, 0);
        chk("arst_bus_consumed", exp_bus.size(), 0);
        exp_bus.delete();
        wait_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_stays_idle", busy, 0);
        run_txn(16'h6000, 16'h7777, 2'b10, 1, 0, 2, 0, 0);

        // Randomized exchanges
        for (int t = 0; t < 30; t++) begin
            sp = (t % 7 == 3) ? 16'hFFFF : 16'($urandom);
            run_txn(sp, 16'($urandom), 2'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    (t % 5 == 2) ? 1 : 0);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
